// File: rtl/fw_rule_match_if.sv
// ---------------------------------------------------------------------------
// fw_rule_match_if
//   Tuple-in / decision-out channel of the firewall rule matcher.
//
//   Tuple channel    : tuple_valid (up->dn), tuple_rdy (dn->up),
//                      src_ip, dst_ip, src_port, dst_port, proto (up->dn)
//   Decision channel : decision_valid, decision_drop, decision_rule (dn->up),
//                      decision_ack (up->dn)
//
//   modport master : the side that produces tuples and consumes decisions
//   modport slave  : the matcher itself
// ---------------------------------------------------------------------------
interface fw_rule_match_if #(
  parameter int IDX_W = 3
);
  logic             tuple_valid;
  logic             tuple_rdy;
  logic [31:0]      src_ip;
  logic [31:0]      dst_ip;
  logic [15:0]      src_port;
  logic [15:0]      dst_port;
  logic [7:0]       proto;

  logic             decision_valid;
  logic             decision_ack;
  logic             decision_drop;
  logic [IDX_W-1:0] decision_rule;

  modport master (
    output tuple_valid, src_ip, dst_ip, src_port, dst_port, proto,
    output decision_ack,
    input  tuple_rdy,
    input  decision_valid, decision_drop, decision_rule
  );

  modport slave (
    input  tuple_valid, src_ip, dst_ip, src_port, dst_port, proto,
    input  decision_ack,
    output tuple_rdy,
    output decision_valid, decision_drop, decision_rule
  );
endinterface

// File: rtl/fw_rule_match.sv
// ---------------------------------------------------------------------------
// fw_rule_match
//   Sequential firewall rule matcher. A 5-tuple is accepted in IDLE, then the
//   rule table is scanned one entry per cycle from index 0; the first enabled
//   entry matching {dst_ip, dst_port (0 = wildcard), proto} drops the packet.
//   With fw_en=0 at accept time the packet is forwarded without a scan.
//   Decisions are held until acknowledged and counted into saturating
//   accepted/dropped counters.
//
//   Ports
//     clk, reset      : clock, synchronous active-high reset
//     tup (slave)     : tuple / decision channel (see fw_rule_match_if)
//     fw_en           : 1 = filter active, 0 = bypass (sampled at accept)
//     rule_wr         : rule-table write strobe
//     rule_idx        : entry written
//     rule_en, rule_dst_ip, rule_dst_port, rule_proto : entry contents
//     cnt_accepted, cnt_dropped : saturating decision counters
// ---------------------------------------------------------------------------
module fw_rule_match #(
  parameter int NUM_RULES = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  fw_rule_match_if.slave   tup,
  input  logic             fw_en,
  input  logic             rule_wr,
  input  logic [IDX_W-1:0] rule_idx,
  input  logic             rule_en,
  input  logic [31:0]      rule_dst_ip,
  input  logic [15:0]      rule_dst_port,
  input  logic [7:0]       rule_proto,
  output logic [31:0]      cnt_accepted,
  output logic [31:0]      cnt_dropped
);

  typedef struct packed {
    logic        en;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [7:0]  proto;
  } rule_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESULT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);
  localparam logic [31:0]      CNT_MAX  = 32'hFFFF_FFFF;

  // -------------------------------------------------------------------------
  // Rule table
  // -------------------------------------------------------------------------
  rule_t rules_q [NUM_RULES];

  // NOTE: this table is a register array, not a RAM macro, so it can and must
  // be cleared by reset; every entry comes up disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        rules_q[i] <= '0;
      end
    end else if (rule_wr) begin
      rules_q[rule_idx] <= {rule_en, rule_dst_ip, rule_dst_port, rule_proto};
    end
  end

  // -------------------------------------------------------------------------
  // Compare of the entry under the scan pointer against the captured tuple.
  // Source address/port never take part in the decision, so no copy of them
  // is kept; only the compared destination fields are held.
  // -------------------------------------------------------------------------
  state_t           state_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic [31:0]      cap_dst_ip_q;
  logic [15:0]      cap_dst_port_q;
  logic [7:0]       cap_proto_q;
  logic             tuple_rdy_q;
  logic             decision_valid_q;
  logic             decision_drop_q;
  logic [IDX_W-1:0] decision_rule_q;

  rule_t cur_rule;
  logic  cur_hit;

  assign cur_rule = rules_q[scan_idx_q];

  // NOTE: every output of a combinational block gets a default on entry, so
  // no path through it leaves a value held and no latch is inferred.
  always_comb begin
    cur_hit = 1'b0;
    if (cur_rule.en &&
        (cur_rule.dst_ip == cap_dst_ip_q) &&
        (cur_rule.proto  == cap_proto_q) &&
        ((cur_rule.dst_port == 16'd0) || (cur_rule.dst_port == cap_dst_port_q))) begin
      cur_hit = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      scan_idx_q       <= '0;
      cap_dst_ip_q     <= '0;
      cap_dst_port_q   <= '0;
      cap_proto_q      <= '0;
      tuple_rdy_q      <= 1'b1;
      decision_valid_q <= 1'b0;
      decision_drop_q  <= 1'b0;
      decision_rule_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tup.tuple_valid) begin
            cap_dst_ip_q   <= tup.dst_ip;
            cap_dst_port_q <= tup.dst_port;
            cap_proto_q    <= tup.proto;
            scan_idx_q     <= '0;
            tuple_rdy_q    <= 1'b0;
            if (fw_en) begin
              state_q <= SCAN;
            end else begin
              // Bypass: forward immediately, no table lookup.
              state_q          <= RESULT;
              decision_valid_q <= 1'b1;
              decision_drop_q  <= 1'b0;
              decision_rule_q  <= '0;
            end
          end
        end

        SCAN: begin
          if (cur_hit) begin
            state_q          <= RESULT;
            decision_valid_q <= 1'b1;
            decision_drop_q  <= 1'b1;
            decision_rule_q  <= scan_idx_q;
          end else if (scan_idx_q == LAST_IDX) begin
            // Last entry missed: forward. Pointer stops here, never wraps.
            state_q          <= RESULT;
            decision_valid_q <= 1'b1;
            decision_drop_q  <= 1'b0;
            decision_rule_q  <= '0;
          end else begin
            scan_idx_q <= scan_idx_q + IDX_W'(1);
          end
        end

        RESULT: begin
          if (tup.decision_ack) begin
            state_q          <= IDLE;
            decision_valid_q <= 1'b0;
            tuple_rdy_q      <= 1'b1;
          end
        end

        default: begin
          state_q          <= IDLE;
          tuple_rdy_q      <= 1'b1;
          decision_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tup.tuple_rdy      = tuple_rdy_q;
  assign tup.decision_valid = decision_valid_q;
  assign tup.decision_drop  = decision_drop_q;
  assign tup.decision_rule  = decision_rule_q;

  // -------------------------------------------------------------------------
  // Saturating decision counters. decision_valid_q is only high in RESULT,
  // so an ack outside RESULT never counts.
  // -------------------------------------------------------------------------
  logic        handshake;
  logic [31:0] cnt_accepted_q, cnt_accepted_d;
  logic [31:0] cnt_dropped_q,  cnt_dropped_d;

  assign handshake = decision_valid_q && tup.decision_ack;

  always_comb begin
    cnt_accepted_d = cnt_accepted_q;
    cnt_dropped_d  = cnt_dropped_q;
    if (handshake) begin
      if (decision_drop_q) begin
        if (cnt_dropped_q != CNT_MAX) cnt_dropped_d = cnt_dropped_q + 32'd1;
      end else begin
        if (cnt_accepted_q != CNT_MAX) cnt_accepted_d = cnt_accepted_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_accepted_q <= '0;
      cnt_dropped_q  <= '0;
    end else begin
      cnt_accepted_q <= cnt_accepted_d;
      cnt_dropped_q  <= cnt_dropped_d;
    end
  end

  assign cnt_accepted = cnt_accepted_q;
  assign cnt_dropped  = cnt_dropped_q;

endmodule
